// File: rtl/dmem_pkg.sv
// Shared definitions for the LSU data memory: RV32I load/store funct3
// codes, the FSM state type and byte-enable / extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    // Byte enables for a lane-0 access of the size in f3[1:0].
    function automatic logic [3:0] be_base(input logic [2:0] f3);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic ill;
        if (we)
            ill = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return ill;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Sign/zero extension of right-aligned load data.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] v;
        case (f3)
            F3_B:    v = {{24{raw[7]}}, raw[7:0]};
            F3_H:    v = {{16{raw[15]}}, raw[15:0]};
            F3_W:    v = raw;
            F3_BU:   v = {24'b0, raw[7:0]};
            F3_HU:   v = {16'b0, raw[15:0]};
            default: v = 32'b0;
        endcase
        return v;
    endfunction

    // Store data copied into every lane so any enabled lane sees it.
    function automatic logic [31:0] replicate(input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] v;
        case (f3[1:0])
            2'b00:   v = {4{d[7:0]}};
            2'b01:   v = {2{d[15:0]}};
            default: v = d;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word RAM with combinational read and byte-enable synchronous write.
// Ports: clk, i_addr (word index), i_we, i_be[3:0], i_wdata, o_rdata.
// Contents are not reset.
module dmem_byte_ram #(
    parameter int MEM_WORDS = 64,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_addr,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b])
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store unit front end over a byte-enabled word RAM. One request per
// valid/ready handshake; response is a one-cycle rsp_valid pulse.
// Ports: clk, reset (async, active high); req_valid/req_ready/req_we/
// req_funct3/req_addr/req_wdata in; rsp_valid/rsp_rdata/rsp_fault out.
// Option: DMEM_MISALIGN_SPLIT_EN splits misaligned H/W accesses over two
// words (LO/HI states); otherwise they fault.
module lsu_data_mem
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t           r_state;
    logic             r_we;
    logic [2:0]       r_f3;
    logic [IDX_W+1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_fault;

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic [4:0]       w_shamt;
    logic             w_fault;
    logic [31:0]      w_load_raw;
    logic [31:0]      w_ram_rdata;
    logic [IDX_W-1:0] w_ram_addr;
    logic             w_ram_we;
    logic [3:0]       w_ram_be;
    logic [31:0]      w_ram_wdata;
    logic             w_unused_addr;

    assign w_unused_addr = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

    assign w_idx   = r_addr[2 +: IDX_W];
    assign w_lane  = r_addr[1:0];
    assign w_shamt = {w_lane, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [31:0] r_lo;
    logic [7:0]  w_be8;
    logic [63:0] w_wd64;
    logic        w_go_lo;

    // Split accesses treat words idx and idx+1 as one 64-bit window.
    assign w_be8   = 8'({4'b0000, be_base(r_f3)} << w_lane);
    assign w_wd64  = 64'({32'b0, r_wdata} << w_shamt);
    assign w_go_lo = !f3_illegal(req_we, req_funct3)
                     && misaligned(req_funct3, req_addr[1:0]);
    assign w_fault = f3_illegal(r_we, r_f3);
    assign w_load_raw = (r_state == S_HI)
                        ? 32'({w_ram_rdata, r_lo} >> w_shamt)
                        : 32'(w_ram_rdata >> w_shamt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lo <= '0;
        else if (r_state == S_LO)
            r_lo <= w_ram_rdata;
    end
`else
    assign w_fault = f3_illegal(r_we, r_f3) | misaligned(r_f3, w_lane);
    assign w_load_raw = 32'(w_ram_rdata >> w_shamt);
`endif

    always_comb begin
        w_ram_addr  = w_idx;
        w_ram_we    = 1'b0;
        w_ram_be    = 4'(be_base(r_f3) << w_lane);
        w_ram_wdata = replicate(r_wdata, r_f3);
        unique case (r_state)
            S_ACC: w_ram_we = r_we & ~w_fault;
`ifdef DMEM_MISALIGN_SPLIT_EN
            S_LO: begin
                w_ram_we    = r_we;
                w_ram_be    = w_be8[3:0];
                w_ram_wdata = w_wd64[31:0];
            end
            S_HI: begin
                w_ram_addr  = w_idx + IDX_W'(1);
                w_ram_we    = r_we;
                w_ram_be    = w_be8[7:4];
                w_ram_wdata = w_wd64[63:32];
            end
`endif
            default: w_ram_we = 1'b0;
        endcase
        // No write may land on an edge where reset is asserted.
        if (reset)
            w_ram_we = 1'b0;
    end

    dmem_byte_ram #(
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W)
    ) u_ram (
        .clk    (clk),
        .i_addr (w_ram_addr),
        .i_we   (w_ram_we),
        .i_be   (w_ram_be),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= req_addr[IDX_W+1:0];
                        r_wdata <= req_wdata;
`ifdef DMEM_MISALIGN_SPLIT_EN
                        r_state <= w_go_lo ? S_LO : S_ACC;
`else
                        r_state <= S_ACC;
`endif
                    end
                end
                S_ACC: begin
                    r_rdata <= (w_fault | r_we) ? 32'b0
                               : extend(w_load_raw, r_f3);
                    r_fault <= w_fault;
                    r_state <= S_RESP;
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                S_LO: r_state <= S_HI;
                S_HI: begin
                    r_rdata <= r_we ? 32'b0 : extend(w_load_raw, r_f3);
                    r_fault <= 1'b0;
                    r_state <= S_RESP;
                end
`endif
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_fault = r_fault;

endmodule
